// File: rtl/spi_byte_engine_if.sv
// Control-bus and SPI pin bundle for spi_byte_engine.
// master = the side issuing ctrl cycles and presenting MISO; slave = the engine.
interface spi_byte_engine_if;
  logic        CTRL_WE;
  logic [15:0] CTRL_A;
  logic        RD_STB;
  logic [2:0]  MISO;
  logic        MOSI;
  logic        SCK;
  logic [1:0]  nSS;
  logic [7:0]  DOUT;
  logic [7:0]  STAT;
  logic        BUSY;

  modport master (
    output CTRL_WE, CTRL_A, RD_STB, MISO,
    input  MOSI, SCK, nSS, DOUT, STAT, BUSY
  );

  modport slave (
    input  CTRL_WE, CTRL_A, RD_STB, MISO,
    output MOSI, SCK, nSS, DOUT, STAT, BUSY
  );
endinterface

// File: rtl/spi_byte_engine.sv
// Single-byte SPI mode-0 master commanded through extended ctrl cycles.
// Ops (CTRL_A[1:0]): 01 start transfer of CTRL_A[15:8], 10 load nSS from
// CTRL_A[9:8], 11 load SCK half-period divider from CTRL_A[15:8], 00 no-op.
// Every command is ignored while a transfer is running.
module spi_byte_engine #(
  parameter logic [3:0] DEV     = 4'hE,
  parameter logic [7:0] DIV_RST = 8'd1
) (
  input  logic               CLKx2,
  input  logic               RESET,
  spi_byte_engine_if.slave   bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOW  = 2'd1,
    ST_HIGH = 2'd2
  } state_t;

  localparam logic [1:0] OP_START = 2'b01;
  localparam logic [1:0] OP_NSS   = 2'b10;
  localparam logic [1:0] OP_DIV   = 2'b11;

  state_t      state_q, state_d;
  logic [7:0]  div_q,   div_d;
  logic [7:0]  cnt_q,   cnt_d;
  logic [2:0]  bit_q,   bit_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  tx_q,    tx_d;
  logic        mosi_q,  mosi_d;
  logic        sck_q,   sck_d;
  logic [1:0]  nss_q,   nss_d;
  logic [7:0]  dout_q,  dout_d;
  logic        done_q,  done_d;

  logic       busy;
  logic       cmd_ok;
  logic [1:0] op;
  logic       expire;
  logic       last_bit;
  logic       rx_bit;
  logic       done_set;

  assign busy     = (state_q != ST_IDLE);
  assign cmd_ok   = bus.CTRL_WE && (bus.CTRL_A[7:4] == DEV) && !busy;
  assign op       = bus.CTRL_A[1:0];
  assign expire   = (cnt_q == 8'd0);
  assign last_bit = (bit_q == 3'd7);

  // Slot select: slot 0/1 follow their own active-low select, slot 2 answers
  // only when neither select is asserted.
  assign rx_bit = (bus.MISO[0] & ~nss_q[0])
                | (bus.MISO[1] & ~nss_q[1])
                | (bus.MISO[2] &  nss_q[0] & nss_q[1]);

  // State and datapath registers, synchronous active-high reset.
  always_ff @(posedge CLKx2) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (RESET) begin
      state_q <= ST_IDLE;
      div_q   <= DIV_RST;
      cnt_q   <= 8'd0;
      bit_q   <= 3'd0;
      shift_q <= 8'd0;
      tx_q    <= 8'd0;
      mosi_q  <= 1'b0;
      sck_q   <= 1'b0;
      nss_q   <= 2'b11;
      dout_q  <= 8'd0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      mosi_q  <= mosi_d;
      sck_q   <= sck_d;
      nss_q   <= nss_d;
      dout_q  <= dout_d;
      done_q  <= done_d;
    end
  end

  // Next-state: start from IDLE, alternate phases on divider expiry.
  always_comb begin
    // NOTE: default assignment first so no path leaves state_d unassigned (no latch).
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (cmd_ok && op == OP_START) state_d = ST_LOW;
      ST_LOW:  if (expire) state_d = ST_HIGH;
      ST_HIGH: if (expire) state_d = last_bit ? ST_IDLE : ST_LOW;
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath/outputs: command decode, divider, shift, completion.
  always_comb begin
    div_d    = div_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    tx_d     = tx_q;
    mosi_d   = mosi_q;
    sck_d    = sck_q;
    nss_d    = nss_q;
    dout_d   = dout_q;
    done_set = 1'b0;

    // The half-period counter reloads on every phase change.
    if (busy) cnt_d = expire ? div_q : (cnt_q - 8'd1);

    unique case (state_q)
      ST_IDLE: begin
        if (cmd_ok) begin
          unique case (op)
            OP_START: begin
              tx_d   = bus.CTRL_A[15:8];
              mosi_d = bus.CTRL_A[15];
              sck_d  = 1'b0;
              bit_d  = 3'd0;
              cnt_d  = div_q;
            end
            OP_NSS:  nss_d = bus.CTRL_A[9:8];
            OP_DIV:  div_d = bus.CTRL_A[15:8];
            default: ;
          endcase
        end
      end
      ST_LOW: begin
        if (expire) begin
          sck_d   = 1'b1;
          shift_d = {shift_q[6:0], rx_bit};
        end
      end
      ST_HIGH: begin
        if (expire) begin
          sck_d = 1'b0;
          if (last_bit) begin
            dout_d   = shift_q;
            done_set = 1'b1;
          end else begin
            tx_d   = {tx_q[6:0], 1'b0};
            mosi_d = tx_q[6];
            bit_d  = bit_q + 3'd1;
          end
        end
      end
      default: ;
    endcase

    // Completion wins over a coincident read acknowledge.
    done_d = done_set | (done_q & ~bus.RD_STB);
  end

  assign bus.MOSI = mosi_q;
  assign bus.SCK  = sck_q;
  assign bus.nSS  = nss_q;
  assign bus.DOUT = dout_q;
  assign bus.BUSY = busy;
  assign bus.STAT = {busy, done_q, 4'b0000, nss_q};

endmodule

// File: tb/tb_spi_byte_engine.sv
// Directed bench for spi_byte_engine: a command vector table plus hand-written
// transfer sequences (loopback, DIV=0, ignored restart, read/done race, reset abort).
module tb_spi_byte_engine;

  logic clk;
  logic rst;
  logic loop_en;
  logic miso0, miso1, miso2;

  int total = 0;
  int bad   = 0;

  spi_byte_engine_if bus ();

  assign bus.MISO = {miso2, miso1, loop_en ? bus.MOSI : miso0};

  spi_byte_engine #(.DEV(4'hE), .DIV_RST(8'd1)) dut (
    .CLKx2 (clk),
    .RESET (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [15:0] a;
    logic [7:0]  exp_stat;
  } vec_t;

  vec_t vecs [7];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Issue a start strobe and follow the transfer until BUSY drops.
  // inject_at: sample index at which a second start (16'hFFE1) is driven.
  // rd_at: sample index at which RD_STB is raised (left high on exit).
  task automatic run_xfer(input logic [15:0] a, input int inject_at, input int rd_at,
                          output int busy_n, output logic [7:0] mosi_pat,
                          output int rises, output int toggles);
    logic prev_sck;
    busy_n   = 0;
    mosi_pat = 8'h00;
    rises    = 0;
    toggles  = 0;
    prev_sck = 1'b0;
    bus.CTRL_A  = a;
    bus.CTRL_WE = 1'b1;
    tick;
    bus.CTRL_WE = 1'b0;
    while (bus.BUSY && busy_n < 400) begin
      if (bus.SCK !== prev_sck) toggles++;
      if (bus.SCK && !prev_sck) begin
        rises++;
        mosi_pat = {mosi_pat[6:0], bus.MOSI};
      end
      prev_sck = bus.SCK;
      if (busy_n == inject_at) begin
        bus.CTRL_A  = 16'hFFE1;
        bus.CTRL_WE = 1'b1;
      end else begin
        bus.CTRL_WE = 1'b0;
      end
      bus.RD_STB = (busy_n == rd_at);
      busy_n++;
      tick;
    end
    bus.CTRL_WE = 1'b0;
    if (bus.BUSY) begin
      total++;
      bad++;
      $display("FAIL xfer_timeout: BUSY still %0b after %0d cycles, expected 0", bus.BUSY, busy_n);
    end
  endtask

  initial begin
    int          busy_n, rises, toggles, n, rcount;
    logic [7:0]  pat;
    logic        prev_sck;

    vecs[0] = '{1'b1, 16'h02E2, 8'h02};  // nSS <= 2'b10
    vecs[1] = '{1'b1, 16'h01D2, 8'h02};  // other device: ignored
    vecs[2] = '{1'b1, 16'hA5D1, 8'h02};  // other device start: ignored
    vecs[3] = '{1'b1, 16'h03E0, 8'h02};  // no-op
    vecs[4] = '{1'b0, 16'h03E2, 8'h02};  // no strobe
    vecs[5] = '{1'b1, 16'h01E2, 8'h01};  // nSS <= 2'b01
    vecs[6] = '{1'b1, 16'h02E2, 8'h02};  // nSS <= 2'b10

    rst         = 1'b1;
    loop_en     = 1'b0;
    miso0       = 1'b0;
    miso1       = 1'b0;
    miso2       = 1'b0;
    bus.CTRL_WE = 1'b0;
    bus.CTRL_A  = 16'h0000;
    bus.RD_STB  = 1'b0;
    tick;
    tick;

    // Reset state
    check("rst_stat", bus.STAT, 8'h03);
    check("rst_busy", bus.BUSY, 1'b0);
    check("rst_sck",  bus.SCK,  1'b0);
    check("rst_mosi", bus.MOSI, 1'b0);
    check("rst_dout", bus.DOUT, 8'h00);
    rst = 1'b0;
    tick;

    // Command table
    for (int i = 0; i < 7; i++) begin
      bus.CTRL_WE = vecs[i].we;
      bus.CTRL_A  = vecs[i].a;
      tick;
      bus.CTRL_WE = 1'b0;
      check($sformatf("vec%0d_stat", i), bus.STAT, vecs[i].exp_stat);
      check($sformatf("vec%0d_busy", i), bus.BUSY, 1'b0);
    end

    // Loopback transfer, DIV=1
    loop_en = 1'b1;
    run_xfer(16'hA5E1, -1, -1, busy_n, pat, rises, toggles);
    check("a5_busy_cycles", busy_n, 32);
    check("a5_sck_rises",   rises,  8);
    check("a5_mosi_pat",    pat,    8'hA5);
    check("a5_dout",        bus.DOUT, 8'hA5);
    check("a5_stat_done",   bus.STAT, 8'h42);
    check("a5_sck_idle",    bus.SCK,  1'b0);
    check("a5_mosi_hold",   bus.MOSI, 1'b1);
    bus.RD_STB = 1'b1;
    tick;
    bus.RD_STB = 1'b0;
    check("a5_rd_clear", bus.STAT, 8'h02);

    // Ignored restart mid-transfer, RD_STB coincident with completion
    run_xfer(16'h3CE1, 15, 31, busy_n, pat, rises, toggles);
    check("3c_busy_cycles", busy_n, 32);
    check("3c_mosi_pat",    pat,    8'h3C);
    check("3c_dout",        bus.DOUT, 8'h3C);
    check("3c_done_race",   bus.STAT, 8'h42);
    tick;
    bus.RD_STB = 1'b0;
    check("3c_rd_next",     bus.STAT, 8'h02);
    tick;
    tick;
    check("3c_single_done", bus.BUSY, 1'b0);
    check("3c_dout_kept",   bus.DOUT, 8'h3C);

    // DIV=0, slot 2 selected
    bus.CTRL_WE = 1'b1;
    bus.CTRL_A  = 16'h00E3;
    tick;
    bus.CTRL_A  = 16'h03E2;
    tick;
    bus.CTRL_WE = 1'b0;
    check("div0_stat_nss", bus.STAT, 8'h03);
    loop_en = 1'b0;
    miso2   = 1'b1;
    run_xfer(16'h00E1, -1, -1, busy_n, pat, rises, toggles);
    check("div0_busy_cycles", busy_n, 16);
    check("div0_toggles",     toggles, 15);
    check("div0_rises",       rises, 8);
    check("div0_dout",        bus.DOUT, 8'hFF);
    check("div0_stat",        bus.STAT, 8'h43);

    // Reset at the 5th SCK rise, with a coincident ctrl write
    bus.CTRL_A  = 16'h5AE1;
    bus.CTRL_WE = 1'b1;
    tick;
    bus.CTRL_WE = 1'b0;
    rcount   = 0;
    prev_sck = 1'b0;
    n        = 0;
    while (n < 200) begin
      if (bus.SCK && !prev_sck) rcount++;
      prev_sck = bus.SCK;
      if (rcount == 5) break;
      n++;
      tick;
    end
    check("abort_rise5_seen", rcount, 5);
    check("abort_busy_pre",   bus.BUSY, 1'b1);
    rst         = 1'b1;
    bus.CTRL_WE = 1'b1;
    bus.CTRL_A  = 16'h02E2;
    tick;
    rst         = 1'b0;
    bus.CTRL_WE = 1'b0;
    check("abort_sck",  bus.SCK,  1'b0);
    check("abort_stat", bus.STAT, 8'h03);
    check("abort_busy", bus.BUSY, 1'b0);
    check("abort_dout", bus.DOUT, 8'h00);
    tick;
    check("abort_no_done", bus.STAT, 8'h03);

    // Divider back at its reset value after reset
    miso2 = 1'b0;
    run_xfer(16'h81E1, -1, -1, busy_n, pat, rises, toggles);
    check("post_rst_busy_cycles", busy_n, 32);
    check("post_rst_mosi_pat",    pat,    8'h81);
    check("post_rst_dout",        bus.DOUT, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spi_byte_engine.md
SPI_BYTE_ENGINE -- requirements
Module: spi_byte_engine

Interface
REQ-001 Parameter DEV, default 4'hE, ctrl device nibble (GA[7:4]) that addresses this engine.
REQ-002 Parameter DIV_RST, default 8'd1, reset value of the SCK half-period divider.
REQ-003 CLKx2  input  1  sole clock; all state changes on rising edge.
REQ-004 RESET  input  1  synchronous, active-high reset.
REQ-005 CTRL_WE  input  1  one-cycle strobe: extended ctrl cycle in progress (upstream nCTRL low, GA[3:2] != 0).
REQ-006 CTRL_A  input  16  ctrl address GA[15:0], valid while CTRL_WE high.
REQ-007 RD_STB  input  1  one-cycle strobe: CPU read of DOUT/STAT completed.
REQ-008 MISO  input  3  serial data in from three slots.
REQ-009 MOSI  output  1  serial data out.
REQ-010 SCK  output  1  serial clock, SPI mode 0.
REQ-011 nSS  output  2  active-low slave selects.
REQ-012 DOUT  output  8  last received byte.
REQ-013 STAT  output  8  {BUSY, DONE, 4'b0000, nSS[1:0]}.
REQ-014 BUSY  output  1  transfer in progress.

Function
REQ-015 Command accepted only when CTRL_WE=1 and CTRL_A[7:4]==DEV.
REQ-016 Op = CTRL_A[1:0]: 01 start transfer, TX byte = CTRL_A[15:8]; 10 nSS <= CTRL_A[9:8]; 11 DIV <= CTRL_A[15:8]; 00 no-op.
REQ-017 Any accepted command while BUSY=1 is ignored entirely (no state change).
REQ-018 Received bit = MISO[0]&!nSS[0] | MISO[1]&!nSS[1] | MISO[2]&nSS[0]&nSS[1], evaluated at each sample point.
REQ-019 States: IDLE, LOW, HIGH; IDLE->LOW on accepted start; LOW->HIGH and HIGH->LOW on divider expiry; HIGH->IDLE on expiry after 8th bit.
REQ-020 Half-period = DIV+1 CLKx2 cycles; DIV=0 gives 1 cycle; divider counter reloads on every phase change.
REQ-021 Start: cycle after strobe BUSY=1, state LOW, MOSI=TX[7], SCK=0, bit counter=0.
REQ-022 LOW expiry: SCK->1, sample received bit into shift LSB.
REQ-023 HIGH expiry: SCK->0, shift left, MOSI=next TX bit MSB-first, bit counter+1; after 8th bit go IDLE.
REQ-024 Transfer length = 16 half-periods = 16*(DIV+1) cycles from BUSY rise to BUSY fall.
REQ-025 On entry to IDLE after transfer: DOUT <= shift register, DONE <= 1, BUSY <= 0, same edge.
REQ-026 SCK=0 in IDLE; MOSI holds last driven value in IDLE.
REQ-027 RD_STB clears DONE; RD_STB in the same cycle as completion: DONE=1 (set wins).
REQ-028 nSS changes only via op 10; engine never toggles nSS itself.
REQ-029 DIV written while IDLE takes effect at next start.

Reset
REQ-030 RESET=1 at a clock edge: state IDLE, BUSY=0, DONE=0, SCK=0, MOSI=0, nSS=2'b11, DOUT=8'h00, DIV=DIV_RST, bit counter=0.
REQ-031 RESET mid-transfer aborts with no DOUT update and no DONE; RESET overrides simultaneous CTRL_WE.

Verification
REQ-032 Reset, op 10 CTRL_A=16'h02E2 (nSS<=2'b10), op 01 CTRL_A=16'hA5E1 with MISO[0] looping MOSI -> SCK 8 pulses, MOSI pattern 1010_0101, DOUT=8'hA5, DONE=1, BUSY high exactly 32 cycles (DIV=1).
REQ-033 DIV<=0 (CTRL_A=16'h00E3), nSS=2'b11, MISO[2]=1, start 16'h00E1 -> BUSY 16 cycles, SCK toggles every cycle, DOUT=8'hFF.
REQ-034 Start 16'h3CE1 while BUSY, second start 16'hFFE1 mid-transfer -> ignored, MOSI pattern 0011_1100, single completion.
REQ-035 Assert RESET at 5th SCK rise -> next cycle SCK=0, nSS=2'b11, BUSY=0, DONE=0, DOUT=8'h00.
REQ-036 RD_STB coincident with completion -> DONE=1; RD_STB next cycle -> DONE=0, STAT=8'h02 with nSS=2'b10.
REQ-037 CTRL_WE with CTRL_A[7:4]=4'hD -> no state change.
